// File: rtl/keypad_debouncer_if.sv
// Handshake bundle between ctrlFSM and the keypad debouncer.
// Combinational wires only; no latency of its own.
// No backpressure: requests are levels and answers are one-cycle pulses.
interface keypad_debouncer_if;
    // dbreq is high while ctrlFSM is in its DEBOUNCE or WAIT state
    logic       dbreq;
    // one-hot column of the key ctrlFSM latched, or 0
    logic [3:0] activeCol;
    // one-cycle answers, never asserted together
    logic       dbhigh;
    logic       dblow;
    // current debouncer state, for debug visibility
    logic [1:0] dbState;

    modport master (
        output dbreq,
        output activeCol,
        input  dbhigh,
        input  dblow,
        input  dbState
    );

    modport slave (
        input  dbreq,
        input  activeCol,
        output dbhigh,
        output dblow,
        output dbState
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Debounces the latched keypad column and answers dbreq with dbhigh/dblow pulses.
// Latency: 2 sync edges, then DB_CYCLES equal samples; pulses are registered (1 cycle).
// No backpressure: ctrlFSM must hold dbreq; dropping it aborts outside the grace window.
module keypad_debouncer #(
    // consecutive equal samples needed to report a level; legal 2 .. 2**CNT_W-1
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         colRaw,
    keypad_debouncer_if.slave  db
);

    // State encodings are also exported on dbState, so keep them fixed.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_TRACK = 2'b01;
    localparam logic [1:0] ST_GRACE = 2'b10;
    localparam logic [1:0] ST_HOLD  = 2'b11;

    // Last count value before a level is declared stable. Reaching it always
    // causes a transition, so the counter can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]       col_meta_q, col_meta_d;
    logic [3:0]       col_sync_q, col_sync_d;
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             cand_q,     cand_d;
    logic             grace_q,    grace_d;
    logic             dbhigh_q,   dbhigh_d;
    logic             dblow_q,    dblow_d;

    // Masked, synchronized sample of the latched key's column.
    logic             samp;

    // Two-flop synchronizer: colRaw is asynchronous to clk.
    always_comb begin
        col_meta_d = colRaw;
        col_sync_d = col_meta_q;
    end

    // Only the latched column matters; other columns are ignored entirely.
    always_comb begin
        samp = |(col_sync_q & db.activeCol);
    end

    // Debounce FSM: next state, stability counter, candidate level and pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        grace_d  = grace_q;
        dbhigh_d = 1'b0;
        dblow_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (db.dbreq) begin
                    // this edge already counts as the first sample
                    state_d = ST_TRACK;
                    cand_d  = samp;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_TRACK: begin
                if (!db.dbreq) begin
                    // abort takes priority even over a just-reached stable level
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (samp != cand_q) begin
                    // bounce: restart counting on the new level
                    cand_d = samp;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (cand_q) begin
                    // stably pressed: report and shield ctrlFSM's UPDATE gap
                    dbhigh_d = 1'b1;
                    state_d  = ST_GRACE;
                    grace_d  = 1'b0;
                    cnt_d    = '0;
                end else begin
                    // stably released without ever being stably pressed
                    dblow_d = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_GRACE: begin
                // dbreq and the sample are deliberately ignored for two edges:
                // one while ctrlFSM is still in DEBOUNCE, one for its UPDATE
                // state, where dbreq drops for a single cycle.
                if (!grace_q) begin
                    grace_d = 1'b1;
                end else begin
                    grace_d = 1'b0;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end

            ST_HOLD: begin
                if (!db.dbreq) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (samp) begin
                    // key still (or again) pressed: release count restarts
                    cnt_d = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    dblow_d = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                // unreachable encodings recover silently
                state_d = ST_IDLE;
                cnt_d   = '0;
                grace_d = 1'b0;
            end
        endcase
    end

    // State and pulse registers; reset discards any debounce in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cand_q     <= 1'b0;
            grace_q    <= 1'b0;
            dbhigh_q   <= 1'b0;
            dblow_q    <= 1'b0;
        end else begin
            col_meta_q <= col_meta_d;
            col_sync_q <= col_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            grace_q    <= grace_d;
            dbhigh_q   <= dbhigh_d;
            dblow_q    <= dblow_d;
        end
    end

    assign db.dbhigh  = dbhigh_q;
    assign db.dblow   = dblow_q;
    assign db.dbState = state_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DB_CYCLES=4 and activeCol=0100.
// Each vector drives one cycle of inputs and checks the registered outputs 1 ns after the edge.
// Pulse totals are tallied on the falling edge and compared at the end.
module tb_keypad_debouncer;

    localparam logic [3:0] P = 4'b0100;  // latched key pressed
    localparam logic [3:0] N = 4'b0000;  // nothing pressed
    localparam logic [3:0] B = 4'b1011;  // other columns only: masked to s=0

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [3:0] colRaw = 4'b1111;

    int n_chk = 0;
    int n_bad = 0;
    int n_hi  = 0;
    int n_lo  = 0;
    int n_both = 0;

    keypad_debouncer_if dbg ();

    keypad_debouncer #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .colRaw (colRaw),
        .db     (dbg.slave)
    );

    always #5 clk = ~clk;

    // pulse tally, sampled mid-cycle so each one-cycle pulse counts once
    always @(negedge clk) begin
        if (dbg.dbhigh) n_hi++;
        if (dbg.dblow) n_lo++;
        if (dbg.dbhigh && dbg.dblow) n_both++;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic eh, input logic el, input logic [1:0] es);
        chk($sformatf("%s.hi", tag), 8'(dbg.dbhigh), 8'(eh));
        chk($sformatf("%s.lo", tag), 8'(dbg.dblow), 8'(el));
        chk($sformatf("%s.st", tag), 8'(dbg.dbState), 8'(es));
    endtask

    // drive one cycle of inputs, take the edge, check the registered outputs
    task automatic vec(input string tag, input logic [3:0] col, input logic req,
                       input logic eh, input logic el, input logic [1:0] es);
        colRaw    = col;
        dbg.dbreq = req;
        @(posedge clk);
        #1;
        chk_outs(tag, eh, el, es);
    endtask

    initial begin
        dbg.dbreq     = 1'b1;
        dbg.activeCol = 4'b0100;

        // ---- reset held with key and request active ----
        #1 rstn = 1'b0;
        #1 chk_outs("rst_async", 1'b0, 1'b0, 2'b00);
        vec("rst_hold0", 4'b1111, 1'b1, 0, 0, 2'b00);
        vec("rst_hold1", 4'b1111, 1'b1, 0, 0, 2'b00);
        vec("rst_hold2", 4'b1111, 1'b1, 0, 0, 2'b00);
        rstn = 1'b1;
        // first edge sees sync=0 so cand=0; the 1 reaches s on edge 3
        vec("rel_e1", 4'b1111, 1'b1, 0, 0, 2'b01);
        vec("rel_e2", 4'b1111, 1'b1, 0, 0, 2'b01);
        vec("rel_e3", 4'b1111, 1'b1, 0, 0, 2'b01);
        vec("rel_e4", 4'b1111, 1'b1, 0, 0, 2'b01);
        vec("rel_e5", 4'b1111, 1'b1, 0, 0, 2'b01);
        vec("rel_e6", 4'b1111, 1'b1, 1, 0, 2'b10);
        vec("rel_e7", 4'b1111, 1'b1, 0, 0, 2'b10);
        vec("rel_e8", 4'b1111, 1'b1, 0, 0, 2'b11);
        // dbreq dropped in HOLD: straight to IDLE, no pulse
        vec("hold_drop", N, 1'b0, 0, 0, 2'b00);
        vec("idle0", N, 1'b0, 0, 0, 2'b00);
        vec("idle1", N, 1'b0, 0, 0, 2'b00);
        vec("idle2", N, 1'b0, 0, 0, 2'b00);

        // ---- clean press, grace gap, bouncy release ----
        vec("cp_pre0", P, 1'b0, 0, 0, 2'b00);
        vec("cp_pre1", P, 1'b0, 0, 0, 2'b00);
        vec("cp_e0", P, 1'b1, 0, 0, 2'b01);
        vec("cp_e1", P, 1'b1, 0, 0, 2'b01);
        vec("cp_e2", P, 1'b1, 0, 0, 2'b01);
        vec("cp_e3", P, 1'b1, 1, 0, 2'b10);
        vec("cp_e4", P, 1'b1, 0, 0, 2'b10);
        vec("cp_gap", P, 1'b0, 0, 0, 2'b11);   // UPDATE gap inside GRACE
        vec("cp_e6", P, 1'b1, 0, 0, 2'b11);
        // colRaw N,N,P,N,N,N,N gives s 0,0,1,0,0,0,0 two edges later
        vec("rel_e7", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e8", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e9", P, 1'b1, 0, 0, 2'b11);
        vec("rel_e10", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e11", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e12", N, 1'b1, 0, 0, 2'b11);  // would fire here without the bounce
        vec("rel_e13", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e14", N, 1'b1, 0, 0, 2'b11);
        vec("rel_e15", N, 1'b1, 0, 1, 2'b00);
        vec("rel_e16", N, 1'b0, 0, 0, 2'b00);

        // ---- bouncy press: s = 1,0,1,1,1,1 ----
        vec("bp_pre0", P, 1'b0, 0, 0, 2'b00);
        vec("bp_pre1", N, 1'b0, 0, 0, 2'b00);
        vec("bp_e0", P, 1'b1, 0, 0, 2'b01);
        vec("bp_e1", P, 1'b1, 0, 0, 2'b01);
        vec("bp_e2", P, 1'b1, 0, 0, 2'b01);
        vec("bp_e3", P, 1'b1, 0, 0, 2'b01);
        vec("bp_e4", P, 1'b1, 0, 0, 2'b01);
        vec("bp_e5", P, 1'b1, 1, 0, 2'b10);
        vec("bp_e6", P, 1'b1, 0, 0, 2'b10);
        vec("bp_e7", P, 1'b0, 0, 0, 2'b11);
        vec("bp_drop", N, 1'b0, 0, 0, 2'b00);
        vec("bp_idle", N, 1'b0, 0, 0, 2'b00);

        // ---- noise only: s = 1,0,0,0,0 (zeros from masked columns) ----
        vec("nz_pre0", P, 1'b0, 0, 0, 2'b00);
        vec("nz_pre1", B, 1'b0, 0, 0, 2'b00);
        vec("nz_e0", B, 1'b1, 0, 0, 2'b01);
        vec("nz_e1", B, 1'b1, 0, 0, 2'b01);
        vec("nz_e2", B, 1'b1, 0, 0, 2'b01);
        vec("nz_e3", B, 1'b1, 0, 0, 2'b01);
        vec("nz_e4", B, 1'b1, 0, 1, 2'b00);
        vec("nz_e5", B, 1'b0, 0, 0, 2'b00);

        // ---- abort in TRACK at cnt=3, same edge as stability (cand=0) ----
        vec("ab0_e0", B, 1'b1, 0, 0, 2'b01);
        vec("ab0_e1", B, 1'b1, 0, 0, 2'b01);
        vec("ab0_e2", B, 1'b1, 0, 0, 2'b01);
        vec("ab0_e3", B, 1'b0, 0, 0, 2'b00);
        vec("ab0_e4", B, 1'b0, 0, 0, 2'b00);

        // ---- abort in TRACK at cnt=3 with cand=1 ----
        vec("ab1_pre0", P, 1'b0, 0, 0, 2'b00);
        vec("ab1_pre1", P, 1'b0, 0, 0, 2'b00);
        vec("ab1_e0", P, 1'b1, 0, 0, 2'b01);
        vec("ab1_e1", P, 1'b1, 0, 0, 2'b01);
        vec("ab1_e2", P, 1'b1, 0, 0, 2'b01);
        vec("ab1_e3", P, 1'b0, 0, 0, 2'b00);
        vec("ab1_e4", P, 1'b0, 0, 0, 2'b00);

        // ---- reset pulsed mid-HOLD ----
        vec("mr_e0", P, 1'b1, 0, 0, 2'b01);
        vec("mr_e1", P, 1'b1, 0, 0, 2'b01);
        vec("mr_e2", P, 1'b1, 0, 0, 2'b01);
        vec("mr_e3", P, 1'b1, 1, 0, 2'b10);
        vec("mr_e4", P, 1'b1, 0, 0, 2'b10);
        vec("mr_e5", P, 1'b1, 0, 0, 2'b11);
        vec("mr_e6", P, 1'b1, 0, 0, 2'b11);
        rstn = 1'b0;
        #1 chk_outs("mr_async", 1'b0, 1'b0, 2'b00);
        vec("mr_rst0", P, 1'b1, 0, 0, 2'b00);
        vec("mr_rst1", P, 1'b1, 0, 0, 2'b00);
        rstn = 1'b1;
        vec("mr_rel0", P, 1'b0, 0, 0, 2'b00);
        vec("mr_rel1", P, 1'b0, 0, 0, 2'b00);

        // ---- pulse totals over the whole run ----
        chk("n_dbhigh", 8'(n_hi), 8'd4);
        chk("n_dblow", 8'(n_lo), 8'd2);
        chk("n_both", 8'(n_both), 8'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
